// File: rtl/board_display_pkg.sv
// Shared definitions for the board front-end: debounce FSM state encodings and the
// active-low hex-to-7-segment table ({g,f,e,d,c,b,a}).
package board_display_pkg;

  typedef enum logic [2:0] {
    ST_LOCKOUT      = 3'd0,
    ST_IDLE         = 3'd1,
    ST_PRESS_WAIT   = 3'd2,
    ST_HELD         = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } db_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder with a blank override.
module hex_to_seg7
  import board_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : SEG_TABLE[i_nibble];

endmodule

// File: rtl/board_display.sv
// Board front-end: debounced single-step clock for the pipeline plus a 4-digit
// multiplexed hex display. Optional leading-zero blanking: DISPLAY_BLANK_LEADING_ZERO_EN.
module board_display
  import board_display_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SCAN_CYC     = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        sel_pc,
  input  logic        sel_hi,
  input  logic [31:0] pc_in,
  input  logic [31:0] reg_in,
  output logic        cpu_clock,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  dbg_state,
  output logic [15:0] dbg_step_cnt
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int SW = $clog2(SCAN_CYC + 1);
  // LOCKOUT counts every low sample itself; the wait states already consumed one
  // qualifying sample on entry, so they stop one count earlier.
  localparam logic [DW-1:0] DB_LAST       = DW'(DEBOUNCE_CYC - 1);
  localparam logic [DW-1:0] DB_ENTRY_LAST = DW'(DEBOUNCE_CYC - 2);
  localparam logic [SW-1:0] SC_LAST       = SW'(SCAN_CYC - 1);

  logic            r_sync1, r_sync2;
  db_state_e       r_state, w_state_nxt;
  logic [DW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_cpu_clock, w_cpu_clock_nxt, w_step_inc;
  logic [15:0]     r_step_cnt;
  logic [SW-1:0]   r_scan_cnt;
  logic [1:0]      r_idx;
  logic [15:0]     r_word, w_sel_word;
  logic [3:0]      r_an;
  logic [6:0]      r_seg, w_seg;
  logic            r_dp, w_blank, w_s, w_scan_last;

  // Synchroniser resets to "pressed" so a button held through reset stays locked out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= step_btn;
      r_sync2 <= r_sync1;
    end
  end
  assign w_s = r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOCKOUT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_LOCKOUT: begin
        if (!w_s) begin
          if (r_cnt == DB_LAST) w_state_nxt = ST_IDLE;
          else                  w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_IDLE: if (w_s) w_state_nxt = ST_PRESS_WAIT;
      ST_PRESS_WAIT: begin
        if (!w_s)                        w_state_nxt = ST_IDLE;
        else if (r_cnt == DB_ENTRY_LAST) w_state_nxt = ST_HELD;
        else                             w_cnt_nxt   = r_cnt + 1'b1;
      end
      ST_HELD: if (!w_s) w_state_nxt = ST_RELEASE_WAIT;
      ST_RELEASE_WAIT: begin
        if (w_s)                         w_state_nxt = ST_HELD;
        else if (r_cnt == DB_ENTRY_LAST) w_state_nxt = ST_IDLE;
        else                             w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = ST_LOCKOUT;
    endcase
  end

  always_comb begin
    w_cpu_clock_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_WAIT);
    w_step_inc      = (w_state_nxt == ST_HELD) &&
                      ((r_state == ST_IDLE) || (r_state == ST_PRESS_WAIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_clock <= 1'b0;
      r_step_cnt  <= '0;
    end else begin
      r_cpu_clock <= w_cpu_clock_nxt;
      if (w_step_inc) r_step_cnt <= r_step_cnt + 16'd1;
    end
  end

  assign w_sel_word  = sel_pc ? (sel_hi ? pc_in[31:16]  : pc_in[15:0])
                              : (sel_hi ? reg_in[31:16] : reg_in[15:0]);
  assign w_scan_last = (r_scan_cnt == SC_LAST);

  // The word is captured only at the frame boundary so one frame never mixes two values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_word     <= '0;
    end else if (w_scan_last) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
      if (r_idx == 2'd3) r_word <= w_sel_word;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

`ifdef DISPLAY_BLANK_LEADING_ZERO_EN
  always_comb begin
    case (r_idx)
      2'd1:    w_blank = (r_word[15:4]  == 12'd0);
      2'd2:    w_blank = (r_word[15:8]  == 8'd0);
      2'd3:    w_blank = (r_word[15:12] == 4'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  hex_to_seg7 u_hex (
    .i_nibble (r_word[4*r_idx +: 4]),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg;
      r_dp  <= !((r_idx == 2'd0) && r_step_cnt[0]);
    end
  end

  assign cpu_clock    = r_cpu_clock;
  assign an           = r_an;
  assign seg          = r_seg;
  assign dp           = r_dp;
  assign dbg_state    = r_state;
  assign dbg_step_cnt = r_step_cnt;

endmodule

// File: tb/tb_board_display.sv
// Bench for board_display: randomized and directed button/display stimulus checked
// against a run-length debounce model and a frame-timed display model.
module tb_board_display;
  import board_display_pkg::*;

  localparam int D     = 8;
  localparam int S     = 4;
  localparam int FRAME = 4 * S;
  localparam logic [6:0] REF_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        step_btn = 1'b0, sel_pc = 1'b0, sel_hi = 1'b0;
  logic [31:0] pc_in = '0, reg_in = '0;
  logic        cpu_clock, dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [2:0]  dbg_state;
  logic [15:0] dbg_step_cnt;

  board_display #(.DEBOUNCE_CYC(D), .SCAN_CYC(S)) dut (
    .clk(clk), .reset(reset), .step_btn(step_btn), .sel_pc(sel_pc), .sel_hi(sel_hi),
    .pc_in(pc_in), .reg_in(reg_in), .cpu_clock(cpu_clock), .an(an), .seg(seg), .dp(dp),
    .dbg_state(dbg_state), .dbg_step_cnt(dbg_step_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [12:0] exp_q[$];

  // reference model state
  logic        p1, p2, last_s, acc, unlocked, m_cpu;
  int          run, n_edge;
  logic [15:0] m_step, m_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [15:0] w, input int d);
    logic [3:0] nib;
    nib = w[4*d +: 4];
`ifdef DISPLAY_BLANK_LEADING_ZERO_EN
    if (d > 0 && (w >> (4*d)) == 16'd0) return 7'h7F;
`endif
    return REF_SEG[nib];
  endfunction

  task automatic model_reset();
    p1 = 1'b1; p2 = 1'b1; last_s = 1'b1; run = 0;
    acc = 1'b1; unlocked = 1'b0; m_cpu = 1'b0;
    m_step = '0; m_word = '0; n_edge = 0;
    exp_q.delete();
  endtask

  // One clock edge: display follows frame timing, button level is accepted after D equal samples.
  task automatic model_step();
    int d;
    logic s, nxt;
    logic [3:0] one, e_an;
    logic [6:0] e_seg;
    logic e_dp;
    one   = 4'b0001;
    d     = (n_edge / S) % 4;
    e_an  = ~(one << d);
    e_seg = ref_seg(m_word, d);
    e_dp  = !(d == 0 && m_step[0]);
    n_edge++;
    if (n_edge % FRAME == 0)
      m_word = sel_pc ? (sel_hi ? pc_in[31:16] : pc_in[15:0])
                      : (sel_hi ? reg_in[31:16] : reg_in[15:0]);
    s = p2; p2 = p1; p1 = step_btn;
    if (s == last_s) run++;
    else begin last_s = s; run = 1; end
    if (run >= D) acc = s;
    if (!acc) unlocked = 1'b1;
    nxt = acc & unlocked;
    if (nxt && !m_cpu) m_step++;
    m_cpu = nxt;
    exp_q.push_back({m_cpu, e_an, e_seg, e_dp});
  endtask

  // driver tasks
  task automatic tick();
    logic [12:0] e;
    @(posedge clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    check("cpu_clock", cpu_clock, e[12]);
    check("an",        an,        e[11:8]);
    check("seg",       seg,       e[7:1]);
    check("dp",        dp,        e[0]);
  endtask

  task automatic check_rst_outputs(input string tag);
    check({tag, "_cpu"}, cpu_clock, 1'b0);
    check({tag, "_an"},  an,        4'b1111);
    check({tag, "_seg"}, seg,       7'h7F);
    check({tag, "_dp"},  dp,        1'b1);
  endtask

  task automatic tick_rst();
    @(posedge clk);
    #1;
    check_rst_outputs("rst");
  endtask

  // Wait until the frame latched after the caller's input change is on digit 0.
  task automatic align_frame();
    do tick(); while (n_edge % FRAME != 0);
    tick();
  endtask

  task automatic wait_cpu(input logic level, output int lat);
    lat = 0;
    while (cpu_clock !== level && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  logic [3:0] t4_an  [4];
  logic [6:0] t4_seg [4];
  logic [6:0] blank_code;
  int lat, found;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    t4_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    t4_seg = '{7'b0000011, 7'b0001000, 7'b0100100, 7'b1111001};
`ifdef DISPLAY_BLANK_LEADING_ZERO_EN
    blank_code = 7'b1111111;
`else
    blank_code = 7'b1000000;
`endif
    model_reset();

    // 1: reset and lockout exit
    repeat (5) tick_rst();
    check("rst_state", dbg_state, ST_LOCKOUT);
    check("rst_step",  dbg_step_cnt, 16'd0);
    reset = 1'b0;
    repeat (9) tick();
    check("lockout_hold", dbg_state, ST_LOCKOUT);
    tick();
    check("lockout_exit", dbg_state, ST_IDLE);
    check("lockout_cpu",  cpu_clock, 1'b0);

    // 2: clean press
    step_btn = 1'b1;
    wait_cpu(1'b1, lat);
    check("rise_lat", lat, D + 2);
    repeat (30 - lat) tick();
    step_btn = 1'b0;
    wait_cpu(1'b0, lat);
    check("fall_lat", lat, D + 2);
    check("step_after_press", dbg_step_cnt, 16'd1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (an == 4'b1110) found = 1;
    end
    check("digit0_seen", found, 1);
    check("dp_digit0", dp, 1'b0);

    // 3: bounce
    repeat (10) begin
      step_btn = ~step_btn;
      repeat (3) tick();
    end
    step_btn = 1'b0;
    repeat (20) tick();
    check("bounce_cpu",  cpu_clock, 1'b0);
    check("bounce_step", dbg_step_cnt, 16'd1);

    // 4 and 5: pc display, mid-frame change
    sel_pc = 1'b1; sel_hi = 1'b0; pc_in = 32'h0040_12AB;
    align_frame();
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) tick();
      check("pc_an",  an,  t4_an[i/S]);
      check("pc_seg", seg, t4_seg[i/S]);
      if (i == S + 1) pc_in = 32'h0000_FFFF;
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      check("ffff_an",  an,  t4_an[i/S]);
      check("ffff_seg", seg, 7'b0001110);
    end

    // 6: register display, leading zeros
    sel_pc = 1'b0; reg_in = 32'h0000_0005;
    align_frame();
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) tick();
      check("reg_seg", seg, (i / S == 0) ? 7'b0010010 : blank_code);
    end

    // reset while HELD, button held through release
    step_btn = 1'b1;
    wait_cpu(1'b1, lat);
    check("held_rise", cpu_clock, 1'b1);
    #3 reset = 1'b1;
    #1;
    check_rst_outputs("held_rst");
    model_reset();
    repeat (2) tick_rst();
    reset = 1'b0;
    repeat (30) tick();
    check("held_through_reset", cpu_clock, 1'b0);
    step_btn = 1'b0;
    repeat (15) tick();
    check("relock_exit", dbg_state, ST_IDLE);

    // random phase
    repeat (150) begin
      step_btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        sel_pc = 1'($urandom_range(0, 1));
        sel_hi = 1'($urandom_range(0, 1));
        pc_in  = $urandom;
        reg_in = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h000F_000F) : $urandom;
      end
      repeat ($urandom_range(1, 20)) tick();
    end
    check("final_step", dbg_step_cnt, m_step);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
